// File: rtl/trap_pkg.sv
// trap_pkg: shared cause codes, FSM state encoding, mie bit indices and trap value selector
package trap_pkg;
   localparam logic [4:0] CAUSE_FETCH_MIS = 5'd0;
   localparam logic [4:0] CAUSE_ILLEGAL   = 5'd2;
   localparam logic [4:0] CAUSE_BREAK     = 5'd3;
   localparam logic [4:0] CAUSE_LOAD_MIS  = 5'd4;
   localparam logic [4:0] CAUSE_STORE_MIS = 5'd6;
   localparam logic [4:0] CAUSE_ECALL_M   = 5'd11;
   localparam logic [4:0] CAUSE_IRQ_MSI   = 5'd3;
   localparam logic [4:0] CAUSE_IRQ_MTI   = 5'd7;
   localparam logic [4:0] CAUSE_IRQ_MEI   = 5'd11;
   localparam int MIE_MSIE = 0;
   localparam int MIE_MTIE = 1;
   localparam int MIE_MEIE = 2;
   typedef enum logic [1:0] {IDLE, ISSUE, REDIRECT} state_e;
   typedef enum logic [1:0] {VAL_ZERO, VAL_PC, VAL_INSTR, VAL_ADDR} val_sel_e;
endpackage

// File: rtl/trap_prio_enc.sv
// trap_prio_enc: picks the winning trap; exceptions always beat interrupts
//   exc     {fetch_mis, illegal, ebreak, ecall, store_mis, load_mis}, already qualified
//   irq     eligible interrupts indexed by MIE_* bit positions
//   valid/is_irq/cause/val_sel  winning trap and which source feeds mtval
module trap_prio_enc
   import trap_pkg::*;
(
   input  logic [5:0] exc,
   input  logic [2:0] irq,
   output logic       valid,
   output logic       is_irq,
   output logic [4:0] cause,
   output val_sel_e   val_sel
);
   always_comb begin
      valid   = |exc | |irq;
      is_irq  = ~|exc & |irq;
      cause   = exc[5] ? CAUSE_FETCH_MIS :
                exc[4] ? CAUSE_ILLEGAL :
                exc[3] ? CAUSE_BREAK :
                exc[2] ? CAUSE_ECALL_M :
                exc[1] ? CAUSE_STORE_MIS :
                exc[0] ? CAUSE_LOAD_MIS :
                irq[MIE_MEIE] ? CAUSE_IRQ_MEI :
                irq[MIE_MSIE] ? CAUSE_IRQ_MSI :
                irq[MIE_MTIE] ? CAUSE_IRQ_MTI : 5'd0;
      val_sel = exc[5] ? VAL_PC :
                exc[4] ? VAL_INSTR :
                exc[3] ? VAL_PC :
                exc[2] ? VAL_ZERO :
                |exc[1:0] ? VAL_ADDR : VAL_ZERO;
   end
endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl: trap arbitration, one request per event, flush/stall during redirect, handler nesting
//   inputs : commit-point state (instr_valid, commit_pc, commit_instr, mem_addr), exception flags,
//            irq_ext/irq_sw/irq_timer, mstatus_mie, mie_bits {MEIE,MTIE,MSIE}, is_mret, epc_taken
//   outputs: exception/interrupt pulses, cause, trap_pc, trap_val, flush, stall, in_handler (all registered)
module trap_ctrl
   import trap_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            instr_valid,
   input  logic [XLEN-1:0] commit_pc,
   input  logic [31:0]     commit_instr,
   input  logic [XLEN-1:0] mem_addr,
   input  logic            exc_fetch_misalign,
   input  logic            exc_illegal,
   input  logic            exc_ebreak,
   input  logic            exc_ecall,
   input  logic            exc_store_misalign,
   input  logic            exc_load_misalign,
   input  logic            irq_ext,
   input  logic            irq_sw,
   input  logic            irq_timer,
   input  logic            mstatus_mie,
   input  logic [2:0]      mie_bits,
   input  logic            is_mret,
   input  logic            epc_taken,
   output logic            exception,
   output logic            interrupt,
   output logic [4:0]      cause,
   output logic [XLEN-1:0] trap_pc,
   output logic [XLEN-1:0] trap_val,
   output logic            flush,
   output logic            stall,
   output logic            in_handler
);
   state_e          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic            seen_q, seen_d, ext_pend_q, ext_pend_d, irq_ext_q;
   logic            exception_q, exception_d, interrupt_q, interrupt_d;
   logic            flush_q, flush_d, stall_q, stall_d, in_handler_q, in_handler_d;
   logic [4:0]      cause_q, cause_d;
   logic [XLEN-1:0] trap_pc_q, trap_pc_d, trap_val_q, trap_val_d;
   logic            ext_rise, p_valid, p_irq, leave;
   logic [5:0]      exc_v;
   logic [2:0]      irq_v;
   logic [4:0]      p_cause;
   val_sel_e        p_sel;
   // a same-cycle rising edge counts as pending so it competes immediately
   assign ext_rise = irq_ext & ~irq_ext_q;
   assign exc_v = {6{instr_valid}} & {exc_fetch_misalign, exc_illegal, exc_ebreak,
                                      exc_ecall, exc_store_misalign, exc_load_misalign};
   assign irq_v = {3{instr_valid & mstatus_mie & ~in_handler_q}} & mie_bits &
                  {ext_pend_q | ext_rise, irq_timer, irq_sw};
   assign leave = cnt_q == 4'd0 && (seen_q | epc_taken);
   trap_prio_enc u_prio (
      .exc     (exc_v),
      .irq     (irq_v),
      .valid   (p_valid),
      .is_irq  (p_irq),
      .cause   (p_cause),
      .val_sel (p_sel)
   );
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      seen_d       = seen_q;
      ext_pend_d   = ext_pend_q | ext_rise;
      exception_d  = 1'b0;
      interrupt_d  = 1'b0;
      flush_d      = 1'b0;
      stall_d      = 1'b0;
      in_handler_d = in_handler_q;
      cause_d      = cause_q;
      trap_pc_d    = trap_pc_q;
      trap_val_d   = trap_val_q;
      case (state_q)
         IDLE: begin
            if (p_valid) begin
               state_d      = ISSUE;
               exception_d  = ~p_irq;
               interrupt_d  = p_irq;
               flush_d      = 1'b1;
               stall_d      = 1'b1;
               in_handler_d = 1'b1;
               seen_d       = 1'b0;
               cnt_d        = 4'(FLUSH_CYCLES - 1);
               cause_d      = p_cause;
               trap_pc_d    = commit_pc;
               trap_val_d   = p_sel == VAL_PC    ? commit_pc :
                              p_sel == VAL_INSTR ? XLEN'(commit_instr) :
                              p_sel == VAL_ADDR  ? mem_addr : '0;
               // MEI outranks every other interrupt, so an irq win with MEI eligible is MEI
               if (p_irq && irq_v[MIE_MEIE]) ext_pend_d = 1'b0;
            end else if (is_mret && instr_valid) begin
               in_handler_d = 1'b0;
            end
         end
         ISSUE: begin
            state_d = REDIRECT;
            seen_d  = epc_taken;
            flush_d = cnt_q != 4'd0;
            cnt_d   = cnt_q != 4'd0 ? cnt_q - 4'd1 : 4'd0;
            stall_d = 1'b1;
         end
         default: begin
            seen_d  = seen_q | epc_taken;
            flush_d = cnt_q != 4'd0;
            cnt_d   = cnt_q != 4'd0 ? cnt_q - 4'd1 : 4'd0;
            state_d = leave ? IDLE : REDIRECT;
            stall_d = ~leave;
         end
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         seen_q       <= 1'b0;
         ext_pend_q   <= 1'b0;
         irq_ext_q    <= 1'b0;
         exception_q  <= 1'b0;
         interrupt_q  <= 1'b0;
         flush_q      <= 1'b0;
         stall_q      <= 1'b0;
         in_handler_q <= 1'b0;
         cause_q      <= '0;
         trap_pc_q    <= '0;
         trap_val_q   <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         seen_q       <= seen_d;
         ext_pend_q   <= ext_pend_d;
         irq_ext_q    <= irq_ext;
         exception_q  <= exception_d;
         interrupt_q  <= interrupt_d;
         flush_q      <= flush_d;
         stall_q      <= stall_d;
         in_handler_q <= in_handler_d;
         cause_q      <= cause_d;
         trap_pc_q    <= trap_pc_d;
         trap_val_q   <= trap_val_d;
      end
   end
   assign exception  = exception_q;
   assign interrupt  = interrupt_q;
   assign cause      = cause_q;
   assign trap_pc    = trap_pc_q;
   assign trap_val   = trap_val_q;
   assign flush      = flush_q;
   assign stall      = stall_q;
   assign in_handler = in_handler_q;
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed plus randomized checks of trap_ctrl against a timeline-based reference model
module tb_trap_ctrl;
   localparam int XLEN = 32;
   localparam int F    = 2;
   logic clk = 1'b0;
   logic rst, instr_valid, exc_fetch_misalign, exc_illegal, exc_ebreak, exc_ecall;
   logic exc_store_misalign, exc_load_misalign, irq_ext, irq_sw, irq_timer, mstatus_mie;
   logic is_mret, epc_taken;
   logic [2:0] mie_bits;
   logic [31:0] commit_pc, commit_instr, mem_addr;
   logic exception, interrupt, flush, stall, in_handler;
   logic [4:0] cause;
   logic [31:0] trap_pc, trap_val;
   int tests = 0, fails = 0;
   // reference model state: trap timeline expressed as cycle numbers
   int cyc = 0, issue_c = 0;
   bit m_busy, m_seen, m_inh, m_pend, m_prev;
   bit e_exc, e_int, e_flush, e_stall;
   logic [4:0] e_cause;
   logic [31:0] e_pc, e_val;

   trap_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(F)) dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .commit_pc(commit_pc),
      .commit_instr(commit_instr), .mem_addr(mem_addr),
      .exc_fetch_misalign(exc_fetch_misalign), .exc_illegal(exc_illegal),
      .exc_ebreak(exc_ebreak), .exc_ecall(exc_ecall),
      .exc_store_misalign(exc_store_misalign), .exc_load_misalign(exc_load_misalign),
      .irq_ext(irq_ext), .irq_sw(irq_sw), .irq_timer(irq_timer),
      .mstatus_mie(mstatus_mie), .mie_bits(mie_bits), .is_mret(is_mret),
      .epc_taken(epc_taken), .exception(exception), .interrupt(interrupt),
      .cause(cause), .trap_pc(trap_pc), .trap_val(trap_val), .flush(flush),
      .stall(stall), .in_handler(in_handler)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   task automatic clr();
      instr_valid = 0; commit_pc = 0; commit_instr = 0; mem_addr = 0;
      exc_fetch_misalign = 0; exc_illegal = 0; exc_ebreak = 0; exc_ecall = 0;
      exc_store_misalign = 0; exc_load_misalign = 0; irq_sw = 0; irq_timer = 0;
      mstatus_mie = 0; mie_bits = 0; is_mret = 0; epc_taken = 1; rst = 0;
   endtask

   task automatic model_step();
      bit rise, found, irq;
      logic ex_f[6];
      int ex_c[6], ex_v[6];
      int v;
      logic [4:0] c;
      ex_f = '{exc_fetch_misalign, exc_illegal, exc_ebreak, exc_ecall, exc_store_misalign, exc_load_misalign};
      ex_c = '{0, 2, 3, 11, 6, 4};
      ex_v = '{0, 1, 0, 2, 3, 3};
      if (rst) begin
         m_busy = 0; m_seen = 0; m_inh = 0; m_pend = 0; m_prev = 0;
         e_exc = 0; e_int = 0; e_cause = 0; e_pc = 0; e_val = 0;
         cyc++;
         e_flush = 0; e_stall = 0;
         return;
      end
      rise = irq_ext && !m_prev;
      e_exc = 0; e_int = 0;
      if (!m_busy) begin
         found = 0; irq = 0; c = 0; v = 2;
         if (instr_valid)
            for (int i = 0; i < 6; i++)
               if (!found && ex_f[i]) begin found = 1; c = 5'(ex_c[i]); v = ex_v[i]; end
         if (!found && instr_valid && mstatus_mie && !m_inh) begin
            v = 2;
            if (mie_bits[2] && (m_pend || rise)) begin found = 1; irq = 1; c = 11; end
            else if (mie_bits[0] && irq_sw) begin found = 1; irq = 1; c = 3; end
            else if (mie_bits[1] && irq_timer) begin found = 1; irq = 1; c = 7; end
         end
         if (found) begin
            e_exc = !irq; e_int = irq; e_cause = c; e_pc = commit_pc;
            e_val = v == 0 ? commit_pc : v == 1 ? commit_instr : v == 3 ? mem_addr : 32'd0;
            m_busy = 1; m_seen = 0; m_inh = 1; issue_c = cyc + 1;
            m_pend = (irq && c == 11) ? 1'b0 : (m_pend || rise);
         end else begin
            if (is_mret && instr_valid) m_inh = 0;
            m_pend = m_pend || rise;
         end
      end else begin
         m_seen = m_seen || epc_taken;
         if (cyc > issue_c && cyc - issue_c >= F - 1 && m_seen) m_busy = 0;
         m_pend = m_pend || rise;
      end
      m_prev = irq_ext;
      cyc++;
      e_flush = m_busy && (cyc - issue_c) < F;
      e_stall = m_busy;
   endtask

   // advance one clock with the currently driven inputs and compare every output to the model
   task automatic step();
      model_step();
      @(posedge clk);
      @(negedge clk);
      chk("exception", 32'(exception), 32'(e_exc));
      chk("interrupt", 32'(interrupt), 32'(e_int));
      chk("cause", 32'(cause), 32'(e_cause));
      chk("trap_pc", trap_pc, e_pc);
      chk("trap_val", trap_val, e_val);
      chk("flush", 32'(flush), 32'(e_flush));
      chk("stall", 32'(stall), 32'(e_stall));
      chk("in_handler", 32'(in_handler), 32'(m_inh));
   endtask

   task automatic drain();
      clr();
      for (int i = 0; i < 4; i++) step();
      instr_valid = 1; is_mret = 1;
      step();
      clr();
   endtask

   initial begin
      irq_ext = 0;
      clr();
      rst = 1;
      @(negedge clk);
      step();
      rst = 0;
      chk("reset_exception", 32'(exception), 0);
      chk("reset_stall", 32'(stall), 0);
      chk("reset_in_handler", 32'(in_handler), 0);
      // illegal instruction
      instr_valid = 1; commit_pc = 32'h100; exc_illegal = 1; commit_instr = 32'hFFFF_FFFF;
      step();
      chk("ill_exception", 32'(exception), 1);
      chk("ill_cause", 32'(cause), 2);
      chk("ill_trap_pc", trap_pc, 32'h100);
      chk("ill_trap_val", trap_val, 32'hFFFF_FFFF);
      chk("ill_flush1", 32'(flush), 1);
      clr();
      step();
      chk("ill_flush2", 32'(flush), 1);
      chk("ill_pulse", 32'(exception), 0);
      step();
      chk("ill_flush3", 32'(flush), 0);
      chk("ill_idle", 32'(stall), 0);
      chk("ill_hold_cause", 32'(cause), 2);
      instr_valid = 1; is_mret = 1;
      step();
      chk("mret_clear", 32'(in_handler), 0);
      // ecall beats load misalign
      clr();
      instr_valid = 1; exc_load_misalign = 1; exc_ecall = 1; mem_addr = 32'h203;
      step();
      chk("ecall_cause", 32'(cause), 11);
      chk("ecall_val", trap_val, 0);
      drain();
      // external edge plus timer: MEI first, MTI after mret
      instr_valid = 1; mstatus_mie = 1; mie_bits = 3'b111; irq_ext = 1; irq_timer = 1; commit_pc = 32'h40;
      step();
      chk("mei_int", 32'(interrupt), 1);
      chk("mei_cause", 32'(cause), 11);
      chk("mei_pc", trap_pc, 32'h40);
      commit_pc = 32'h80;
      step();
      step();
      is_mret = 1;
      step();
      chk("mei_mret", 32'(in_handler), 0);
      is_mret = 0; commit_pc = 32'h84;
      step();
      chk("mti_int", 32'(interrupt), 1);
      chk("mti_cause", 32'(cause), 7);
      chk("mti_pc", trap_pc, 32'h84);
      irq_ext = 0;
      drain();
      // masked timer, then enable
      instr_valid = 1; irq_timer = 1; mie_bits = 3'b111;
      for (int i = 0; i < 20; i++) begin
         step();
         chk("masked_timer", 32'(interrupt), 0);
      end
      mstatus_mie = 1;
      step();
      chk("unmask_int", 32'(interrupt), 1);
      chk("unmask_cause", 32'(cause), 7);
      drain();
      // withheld redirect acknowledge
      instr_valid = 1; exc_ecall = 1; epc_taken = 0;
      step();
      exc_ecall = 0; instr_valid = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("epc_wait_stall", 32'(stall), 1);
      end
      epc_taken = 1;
      step();
      chk("epc_release", 32'(stall), 0);
      drain();
      // reset mid-redirect while an external edge is pending behind an exception
      instr_valid = 1; exc_illegal = 1; mstatus_mie = 1; mie_bits = 3'b111; irq_ext = 1; epc_taken = 0;
      step();
      chk("exc_over_irq", 32'(exception), 1);
      exc_illegal = 0;
      step();
      rst = 1; irq_ext = 0;
      step();
      chk("rst_stall", 32'(stall), 0);
      chk("rst_flush", 32'(flush), 0);
      chk("rst_in_handler", 32'(in_handler), 0);
      chk("rst_cause", 32'(cause), 0);
      rst = 0; epc_taken = 1;
      step();
      chk("rst_pend_clear", 32'(interrupt), 0);
      clr();
      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom % 400) == 0;
         instr_valid = ($urandom % 4) != 0;
         commit_pc = $urandom; commit_instr = $urandom; mem_addr = $urandom;
         exc_fetch_misalign = ($urandom % 20) == 0;
         exc_illegal = ($urandom % 20) == 0;
         exc_ebreak = ($urandom % 20) == 0;
         exc_ecall = ($urandom % 20) == 0;
         exc_store_misalign = ($urandom % 20) == 0;
         exc_load_misalign = ($urandom % 20) == 0;
         if (($urandom % 8) == 0) irq_ext = ~irq_ext;
         if (($urandom % 10) == 0) irq_sw = ~irq_sw;
         if (($urandom % 10) == 0) irq_timer = ~irq_timer;
         if (($urandom % 20) == 0) mie_bits = 3'($urandom);
         if (($urandom % 15) == 0) mstatus_mie = ~mstatus_mie;
         is_mret = ($urandom % 5) == 0;
         epc_taken = ($urandom % 3) != 0;
         step();
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
